// File: rtl/ror4_pkg.sv
// Shared definitions for the iterative right-shift/rotate unit (ror4_seq).
package ror4_pkg;

    localparam int ROR_W     = 4;
    localparam int ROR_CNT_W = 2;

    // Mode bit latched with the operand: zero-fill shift or rotate.
    localparam logic MODE_SHL0 = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : ror4_pkg

// File: rtl/ror1_step.sv
// One-position right step: rotate (wrap bit 0 to the MSB) or logical shift
// (zero fill). bit_out is the bit leaving position 0.
module ror1_step
    import ror4_pkg::*;
#(
    parameter int WIDTH = ROR_W
) (
    input  logic [WIDTH-1:0] d,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             bit_out
);

    // Select fill bit for the vacated MSB from the mode.
    always_comb begin
        bit_out = d[0];
        if (rot == MODE_ROT) begin
            q = {d[0], d[WIDTH-1:1]};
        end else begin
            q = {1'b0, d[WIDTH-1:1]};
        end
    end

endmodule : ror1_step

// File: rtl/ror4_seq.sv
// Iterative right-shift/rotate unit: latches operand, amount and mode on an
// accepted start, moves one bit per clock, then pulses done with the result.
// Optional feature: define ROR4_CARRY_EN to add the cout port (last bit
// shifted out, registered alongside out).
module ror4_seq
    import ror4_pkg::*;
#(
    parameter int WIDTH = ROR_W,
    parameter int CNT_W = ROR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] s,
    input  logic             rot,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef ROR4_CARRY_EN
    ,
    output logic             cout
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] wreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mode_r;
    logic [WIDTH-1:0] out_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic [WIDTH-1:0] res_s;
    logic             res_cout_s;
    logic [WIDTH-1:0] step_q_s;
    logic             step_bit_s;

    // Start is only honoured outside SHIFT; a start in DONE chains directly.
    assign load_s = start && (state_r != SHIFT);

    ror1_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d       (wreg_r),
        .rot     (mode_r),
        .q       (step_q_s),
        .bit_out (step_bit_s)
    );

    // Next-state decode and the value captured into out on entry to DONE.
    always_comb begin
        state_nxt_s = state_r;
        res_s       = step_q_s;
        res_cout_s  = step_bit_s;
        case (state_r)
            IDLE, DONE: begin
                if (load_s) begin
                    // Zero-amount request completes straight away with in unchanged.
                    res_s      = in;
                    res_cout_s = 1'b0;
                    if (s != '0) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // The final step's result goes straight into out so it is
                // valid during the done cycle.
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            wreg_r  <= '0;
            cnt_r   <= '0;
            mode_r  <= MODE_SHL0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                wreg_r <= in;
                cnt_r  <= s;
                mode_r <= rot;
            end else if (state_r == SHIFT) begin
                wreg_r <= step_q_s;
                cnt_r  <= cnt_r - CNT_ONE;
            end else begin
                wreg_r <= wreg_r;
                cnt_r  <= cnt_r;
            end
            busy_r <= (state_nxt_s == SHIFT);
            done_r <= (state_nxt_s == DONE);
            if (state_nxt_s == DONE) begin
                out_r <= res_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef ROR4_CARRY_EN
    logic cout_r;

    // Carry of the final step, captured and held together with out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout_r <= 1'b0;
        end else if (state_nxt_s == DONE) begin
            cout_r <= res_cout_s;
        end else begin
            cout_r <= cout_r;
        end
    end

    assign cout = cout_r;
`else
    logic unused_carry_s;
    assign unused_carry_s = res_cout_s;
`endif

endmodule : ror4_seq

// File: tb/tb_ror4_seq.sv
// Directed self-checking bench for ror4_seq. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
module tb_ror4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] in_v;
    logic [1:0] s_v;
    logic       rot;
    logic [3:0] out_v;
    logic       busy;
    logic       done;
`ifdef ROR4_CARRY_EN
    logic       cout_v;
`endif

    int checks   = 0;
    int failures = 0;

    ror4_seq #(
        .WIDTH (4),
        .CNT_W (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_v),
        .s     (s_v),
        .rot   (rot),
        .out   (out_v),
        .busy  (busy),
        .done  (done)
`ifdef ROR4_CARRY_EN
        ,
        .cout  (cout_v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start for a single cycle, then watch 8 cycles.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [1:0] sh,
                          input logic r, input logic [3:0] exp, input logic exp_c);
        int lat  = 0;
        int dcnt = 0;
        int bcnt = 0;
        @(negedge clk);
        in_v = a; s_v = sh; rot = r; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                in_v = ~a; s_v = ~sh; rot = ~r;
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = k;
                    check({tag, "_out"}, 32'(out_v), 32'(exp));
`ifdef ROR4_CARRY_EN
                    check({tag, "_cout"}, 32'(cout_v), 32'(exp_c));
`endif
                end
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(sh) + 32'd1);
        check({tag, "_dcnt"}, 32'(dcnt), 32'd1);
        check({tag, "_busy"}, 32'(bcnt), 32'(sh));
        check({tag, "_hold"}, 32'(out_v), 32'(exp));
        if (exp_c) begin end
    endtask

    initial begin
        int lat;
        int dcnt;
        rst = 1'b1; start = 1'b0; in_v = 4'b0000; s_v = 2'd0; rot = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_v), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef ROR4_CARRY_EN
        check("rst_cout", 32'(cout_v), 32'd0);
`endif
        rst = 1'b0;

        run_op("s1_rot",  4'b1001, 2'd1, 1'b1, 4'b1100, 1'b1);
        run_op("s2_shr",  4'b1001, 2'd1, 1'b0, 4'b0100, 1'b1);
        run_op("s3_rot",  4'b0110, 2'd3, 1'b1, 4'b1100, 1'b1);
        run_op("s3_shr",  4'b0110, 2'd3, 1'b0, 4'b0000, 1'b1);
        run_op("s4_zero", 4'b1011, 2'd0, 1'b0, 4'b1011, 1'b0);
        run_op("s4_zrot", 4'b0110, 2'd0, 1'b1, 4'b0110, 1'b0);

        // Start accepted from DONE chains straight into the next operation.
        @(negedge clk);
        in_v = 4'b1011; s_v = 2'd0; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        check("chain_done1", 32'(done), 32'd1);
        check("chain_out1", 32'(out_v), 32'hb);
        in_v = 4'b1001; s_v = 2'd1; rot = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("chain_busy", 32'(busy), 32'd1);
        check("chain_done_lo", 32'(done), 32'd0);
        @(negedge clk);
        check("chain_done2", 32'(done), 32'd1);
        check("chain_out2", 32'(out_v), 32'hc);
        repeat (2) @(negedge clk);

        // Second start while busy is ignored.
        lat = 0; dcnt = 0;
        @(negedge clk);
        in_v = 4'b0001; s_v = 2'd3; rot = 1'b1; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_v = 4'b1111; s_v = 2'd1; rot = 1'b0;
            end
            if (k == 2) start = 1'b0;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = k;
                    check("s5_out", 32'(out_v), 32'h2);
`ifdef ROR4_CARRY_EN
                    check("s5_cout", 32'(cout_v), 32'd0);
`endif
                end
            end
        end
        check("s5_lat", 32'(lat), 32'd4);
        check("s5_dcnt", 32'(dcnt), 32'd1);

        // Reset mid-operation aborts without a done pulse.
        dcnt = 0;
        @(negedge clk);
        in_v = 4'b0110; s_v = 2'd3; rot = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s6_out", 32'(out_v), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("s6_nodone", 32'(dcnt), 32'd0);

        // Reset and start together: reset wins.
        dcnt = 0;
        @(negedge clk);
        in_v = 4'b1001; s_v = 2'd1; rot = 1'b1; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rs_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("rs_nodone", 32'(dcnt), 32'd0);

        run_op("s6_fresh", 4'b1001, 2'd1, 1'b1, 4'b1100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ror4_seq
